// File: rtl/data_sram_pkg.sv
// ---------------------------------------------------------------------------
// data_sram_pkg : shared data-SRAM interface constants and parameter bounds
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package data_sram_pkg;

  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam int RESP_DELAY_MIN  = 1;
  localparam int RESP_DELAY_MAX  = 4;
  localparam int OUTSTANDING_MIN = 1;
  localparam int OUTSTANDING_MAX = 4;

  // Countdown holds RESP_DELAY-1 (max 3); count holds up to OUTSTANDING_MAX (4)
  localparam int CD_W  = 2;
  localparam int CNT_W = 3;

endpackage

`default_nettype wire

// File: rtl/data_sram_resp_fifo.sv
// ---------------------------------------------------------------------------
// data_sram_resp_fifo : in-order response queue with per-entry countdowns
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module data_sram_resp_fifo
  import data_sram_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int RESP_DELAY = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  output logic [CNT_W-1:0]  count,
  output logic              data_ok,
  output logic [DATA_W-1:0] rdata
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CD_W-1:0] CD_INIT = CD_W'(RESP_DELAY - 1);

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [CD_W-1:0]   cd_q   [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Later entries never have a smaller countdown than the head, so only the head is checked
  assign data_ok = (count != '0) && (cd_q[rd_ptr] == '0);
  assign rdata   = data_ok ? data_q[rd_ptr] : '0;
  assign pop     = data_ok;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        cd_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (cd_q[i] != '0) begin
          cd_q[i] <= cd_q[i] - CD_W'(1);
        end
      end
      if (push) begin
        data_q[wr_ptr] <= push_data;
        cd_q[wr_ptr]   <= CD_INIT;
        wr_ptr         <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (!push && pop) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/data_sram_responder.sv
// ---------------------------------------------------------------------------
// data_sram_responder : word-addressed data SRAM with delayed in-order responses
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module data_sram_responder
  import data_sram_pkg::*;
#(
  parameter int AW          = 10,
  parameter int RESP_DELAY  = 1,
  parameter int OUTSTANDING = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              data_sram_req,
  input  logic              data_sram_wr,
  input  logic [1:0]        data_sram_size,
  input  logic [STRB_W-1:0] data_sram_wstrb,
  input  logic [31:0]       data_sram_addr,
  input  logic [DATA_W-1:0] data_sram_wdata,
  output logic              data_sram_addr_ok,
  output logic              data_sram_data_ok,
  output logic [DATA_W-1:0] data_sram_rdata
);

  if (AW < 1 || AW > 29) begin : g_bad_aw
    $error("data_sram_responder: AW must be in 1..29");
  end
  if (RESP_DELAY < RESP_DELAY_MIN || RESP_DELAY > RESP_DELAY_MAX) begin : g_bad_delay
    $error("data_sram_responder: RESP_DELAY must be in 1..4");
  end
  if (OUTSTANDING < OUTSTANDING_MIN || OUTSTANDING > OUTSTANDING_MAX) begin : g_bad_outstanding
    $error("data_sram_responder: OUTSTANDING must be in 1..4");
  end

  localparam int DEPTH = 1 << AW;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     idx;
  logic              accept;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] push_data;
  logic              unused_ok;

  // Size and the non-index address bits carry no meaning here; upper addresses alias
  assign unused_ok = ^{data_sram_size, data_sram_addr};

  assign idx               = data_sram_addr[AW+1:2];
  assign data_sram_addr_ok = resetn && (count < CNT_W'(OUTSTANDING));
  assign accept            = data_sram_req && data_sram_addr_ok;

  // Read sees the array before this edge's update, which already holds earlier writes
  assign push_data = data_sram_wr ? '0 : mem[idx];

  always_ff @(posedge clk) begin
    if (accept && data_sram_wr) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (data_sram_wstrb[i]) begin
          mem[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
        end
      end
    end
  end

  data_sram_resp_fifo #(
    .DEPTH      (OUTSTANDING),
    .RESP_DELAY (RESP_DELAY)
  ) u_resp_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (accept),
    .push_data (push_data),
    .count     (count),
    .data_ok   (data_sram_data_ok),
    .rdata     (data_sram_rdata)
  );

endmodule

`default_nettype wire
